// File: rtl/ps2_line_buffer.sv
// ps2_line_buffer
//   Collects PS/2 scancode bytes into a line buffer for the command parser.
//   Key-release (break) pairs are discarded, backspace removes the newest
//   character, and Enter commits the line. A committed line stays frozen
//   until the consumer acknowledges it.
//
// Ports
//   clock       system clock, all state on the rising edge
//   reset       asynchronous active-low reset
//   ps2_info    scancode byte from the PS/2 receiver
//   ps2_enable  byte strobe, one byte accepted per rising edge of the strobe
//   line_ack    consumer has taken the committed line
//   rd_addr     random-access read index (0 = oldest character)
//   out         newest CHARS characters, newest in the low slot, empty slots 0
//   rd_data     character at rd_addr, 0 beyond the end of the line
//   count       number of characters in the line
//   full        line holds DEPTH characters
//   line_valid  line committed and awaiting line_ack
//   overflow    sticky: a character was dropped because the line was full
//
// State table
//   IDLE   | accepting characters, backspace and Enter
//   LOCKED | line committed, contents frozen until line_ack
module ps2_line_buffer #(
  parameter int                    CHAR_WIDTH     = 8,
  parameter int                    CHARS          = 4,
  parameter int                    DEPTH          = 16,
  parameter logic [CHAR_WIDTH-1:0] BREAK_CODE     = 8'hF0,
  parameter logic [CHAR_WIDTH-1:0] BACKSPACE_CODE = 8'h66,
  parameter logic [CHAR_WIDTH-1:0] ENTER_CODE     = 8'h5A
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CHAR_WIDTH-1:0]         ps2_info,
  input  logic                          ps2_enable,
  input  logic                          line_ack,
  input  logic [$clog2(DEPTH)-1:0]      rd_addr,
  output logic [CHARS*CHAR_WIDTH-1:0]   out,
  output logic [CHAR_WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          line_valid,
  output logic                          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state_q;
  logic                  en_q;
  logic                  break_pending_q;
  logic [CW-1:0]         count_q;
  logic                  line_valid_q;
  logic                  overflow_q;
  logic [CHAR_WIDTH-1:0] mem_q [DEPTH];

  logic          accept;
  logic          char_ev;
  logic          full_w;
  logic          wr_en;
  logic [AW-1:0] wr_idx;

  assign accept = ps2_enable & ~en_q;
  // A byte reaches the line logic only when it is neither a break prefix
  // nor the byte that follows one, and the line is still open.
  assign char_ev = accept & ~break_pending_q & (ps2_info != BREAK_CODE) &
                   (state_q == IDLE);
  assign full_w  = (count_q == CW'(DEPTH));
  assign wr_idx  = AW'(count_q);
  assign wr_en   = char_ev & (ps2_info != BACKSPACE_CODE) &
                   (ps2_info != ENTER_CODE) & ~full_w;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      en_q            <= 1'b0;
      break_pending_q <= 1'b0;
      count_q         <= '0;
      line_valid_q    <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      en_q <= ps2_enable;

      // Break tracking runs in every state so a release seen while the
      // line is locked cannot leak its key byte into the next line.
      if (accept) begin
        if (break_pending_q) begin
          break_pending_q <= 1'b0;
        end else if (ps2_info == BREAK_CODE) begin
          break_pending_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (char_ev) begin
            if (ps2_info == BACKSPACE_CODE) begin
              if (count_q != '0) begin
                count_q <= count_q - 1'b1;
              end
            end else if (ps2_info == ENTER_CODE) begin
              if (count_q != '0) begin
                line_valid_q <= 1'b1;
                state_q      <= LOCKED;
              end
            end else if (!full_w) begin
              count_q <= count_q + 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (line_ack) begin
            count_q      <= '0;
            line_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage carries no reset: entries beyond count are never observed.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_idx] <= ps2_info;
    end
  end

  logic [AW-1:0] win_idx;

  always_comb begin
    out     = '0;
    win_idx = '0;
    for (int i = 0; i < CHARS; i++) begin
      if (count_q > CW'(i)) begin
        win_idx = AW'(count_q - CW'(i + 1));
        out[i*CHAR_WIDTH +: CHAR_WIDTH] = mem_q[win_idx];
      end
    end
  end

  assign rd_data    = (CW'(rd_addr) < count_q) ? mem_q[rd_addr] : '0;
  assign count      = count_q;
  assign full       = full_w;
  assign line_valid = line_valid_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/ps2_line_buffer.md
Name: ps2_line_buffer

Overview:
- Parametrised successor to characterData: captures PS/2 scancode bytes into a line buffer.
- Filters break sequences, applies backspace, and commits a line on Enter.
- Exposes two views of the buffer: a packed window of the newest CHARS characters, and a random-access read port.
- Sits between the PS/2 receiver (ps2_info/ps2_enable) and the command parser, which consumes committed lines via a valid/ack handshake.

Parameters:
- CHAR_WIDTH, 8, bits per scancode.
- CHARS, 4, characters in packed window out (out width = CHARS*CHAR_WIDTH).
- DEPTH, 16, line capacity in characters; DEPTH >= CHARS, DEPTH >= 2.
- BREAK_CODE, 8'hF0, prefix marking a key release.
- BACKSPACE_CODE, 8'h66, deletes newest character.
- ENTER_CODE, 8'h5A, commits line.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ps2_info  in  CHAR_WIDTH  scancode from PS/2 receiver.
- ps2_enable  in  1  byte strobe; byte accepted on its rising edge only.
- line_ack  in  1  consumer has taken the committed line.
- rd_addr  in  $clog2(DEPTH)  read index into line (0 = oldest).
- out  out  CHARS*CHAR_WIDTH  newest char in bits [CHAR_WIDTH-1:0], next-newest above; empty slots 0.
- rd_data  out  CHAR_WIDTH  buf[rd_addr] if rd_addr < count, else 0 (combinational).
- count  out  $clog2(DEPTH+1)  characters in line.
- full  out  1  count == DEPTH.
- line_valid  out  1  line committed, awaiting ack.
- overflow  out  1  sticky: a character was dropped because the line was full.

Behaviour:
- Reset (reset=0, async):
  - count=0, line_valid=0, overflow=0, break_pending=0, state=IDLE, en_q=0.
  - out=0, rd_data=0, full=0; buffer contents don't-care.
- Edge detect:
  - en_q <= ps2_enable every clock.
  - Accept event = ps2_enable & ~en_q; ps2_info sampled in the same clock.
  - Enable held high = one event. Enable high at reset release = one event.
- Effects of an accepted byte visible on the clock edge after acceptance. out, full and rd_data derive combinationally from buffer/count, so they share the same 1-cycle latency.
- break_pending, evaluated in any state and before all other rules:
  - Byte == BREAK_CODE: set break_pending, byte dropped.
  - break_pending=1: next byte is dropped, break_pending cleared.
- State IDLE, non-break byte b:
  - b == BACKSPACE_CODE: count>0 -> count-1; count==0 -> no change. overflow unchanged.
  - b == ENTER_CODE: count>0 -> line_valid=1, state LOCKED; count==0 -> ignored.
  - Otherwise: count<DEPTH -> buf[count]=b, count+1; count==DEPTH -> byte dropped, overflow=1.
- State LOCKED:
  - Non-break bytes dropped, with no effect on count or overflow. Break tracking still runs.
  - Buffer, count and out frozen.
  - line_ack=1 -> next clock: count=0, line_valid=0, overflow=0, state IDLE.
  - Ack and accept event in the same cycle: ack wins, byte dropped.
- line_ack in IDLE: ignored.
- Window: out slot i (i=0..CHARS-1) = buf[count-1-i] if count>i, else 0. Backspace therefore shifts the window down and exposes the older character.
- Reset mid-line or mid-break: everything cleared immediately; a pending break is forgotten.

Test Plan:
1. Reset released, ps2_enable pulses (2 clocks high) with 8'h21, 8'h22, 8'h23 -> count=3; out=32'h00212223 one clock after the third edge; rd_addr=0 gives 8'h21.
2. Hold ps2_enable high 10 clocks while ps2_info increments each clock -> exactly one byte captured (the value at the rising edge); count=1.
3. Bytes 8'h1C, 8'hF0, 8'h1C, 8'h32 -> break pair dropped; count=2, out=32'h00001C32. Then 8'h66 -> count=1, out=32'h0000001C.
4. 17 chars 8'h01..8'h11 with DEPTH=16 -> full=1 after the 16th; the 17th is dropped; overflow=1; out=32'h0D0E0F10.
5. Chars 8'h2C, 8'h24, then 8'h5A -> line_valid=1. Bytes 8'h33 then dropped, out unchanged. Then line_ack pulse -> next clock count=0, line_valid=0, out=0.
6. 8'h5A with count=0 -> line_valid stays 0. Then reset pulsed low mid-stream after 8'hF0 -> next byte 8'h15 is captured (count=1); all outputs cleared during reset.
